// File: rtl/muldiv_issue_ctrl.sv
// muldiv_issue_ctrl
// Issue/writeback controller between the RV32 execute stage and an unsigned
// 32-bit shift-add/shift-subtract multiply-divide unit. It converts signed
// RV32M ops into unsigned unit operations, applies the sign fix-up to the
// returned value, handles divide-by-zero locally, and stalls the core while
// an operation is outstanding.
module muldiv_issue_ctrl #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [2:0]        req_op,
    input  logic [XLEN-1:0]   req_a,
    input  logic [XLEN-1:0]   req_b,
    input  logic [4:0]        req_rd,
    input  logic              flush,
    output logic              busy,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_data,
    output logic [4:0]        resp_rd,
    output logic              md_valid,
    output logic              md_mode,
    output logic [XLEN-1:0]   md_a,
    output logic [XLEN-1:0]   md_b,
    input  logic              md_ready,
    input  logic [2*XLEN-1:0] md_out
);

    // RV32M funct3 encodings
    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    // Controller states
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LAUNCH = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_RESP   = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;

    logic [2:0]      state;
    logic [2:0]      state_next;
    logic [2:0]      op_q;
    logic [4:0]      rd_q;
    logic            sign_a_q;
    logic            sign_b_q;
    logic            drain_done;

    logic            accept;
    logic            signed_a;
    logic            signed_b;
    logic            neg_a;
    logic            neg_b;
    logic            div_zero;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   result;

    // Status strobes are pure decodes of the current state
    always_comb begin
        busy       = (state != S_IDLE);
        md_valid   = (state == S_LAUNCH);
        resp_valid = (state == S_RESP);
    end

    // Request decode: which operands are signed, their magnitudes, div-by-zero
    always_comb begin
        accept   = (state == S_IDLE) && req_valid && !flush;
        signed_a = (req_op == OP_MULH) || (req_op == OP_MULHSU) ||
                   (req_op == OP_DIV)  || (req_op == OP_REM);
        signed_b = (req_op == OP_MULH) || (req_op == OP_DIV) || (req_op == OP_REM);
        neg_a    = signed_a && req_a[XLEN-1];
        neg_b    = signed_b && req_b[XLEN-1];
        abs_a    = neg_a ? ('0 - req_a) : req_a;
        abs_b    = neg_b ? ('0 - req_b) : req_b;
        div_zero = req_op[2] && (req_b == '0);
    end

    // Sign fix-up of the unsigned unit result and selection of the result word
    always_comb begin
        prod_fix = (sign_a_q ^ sign_b_q) ? ('0 - md_out) : md_out;
        quot_fix = (sign_a_q ^ sign_b_q) ? ('0 - md_out[XLEN-1:0]) : md_out[XLEN-1:0];
        rem_fix  = sign_a_q ? ('0 - md_out[2*XLEN-1:XLEN]) : md_out[2*XLEN-1:XLEN];
        case (op_q)
            OP_MUL:                        result = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  result = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               result = quot_fix;
            OP_REM, OP_REMU:               result = rem_fix;
            default:                       result = '0;
        endcase
    end

    // Next-state logic
    always_comb begin
        // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
        state_next = state;
        case (state)
            S_IDLE:   if (accept) state_next = div_zero ? S_RESP : S_LAUNCH;
            S_LAUNCH: state_next = flush ? S_DRAIN : S_WAIT;
            S_WAIT: begin
                if (flush)         state_next = S_DRAIN;
                else if (md_ready) state_next = S_RESP;
            end
            S_RESP:   state_next = S_IDLE;
            S_DRAIN:  if (md_ready || drain_done) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Request capture, unit operands and writeback result registers
    always_ff @(posedge clk) begin
        // NOTE: every register here is plain flops (no RAM), so all get a defined reset value.
        if (rst) begin
            op_q       <= '0;
            rd_q       <= '0;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            drain_done <= 1'b0;
            md_mode    <= 1'b0;
            md_a       <= '0;
            md_b       <= '0;
            resp_data  <= '0;
            resp_rd    <= '0;
        end else begin
            // A result landing in the same cycle as a flush lets DRAIN exit without waiting
            drain_done <= (state == S_WAIT) && flush && md_ready;

            if (accept) begin
                op_q     <= req_op;
                rd_q     <= req_rd;
                sign_a_q <= neg_a;
                sign_b_q <= neg_b;
                if (div_zero) begin
                    // DIV/DIVU give all ones, REM/REMU give the dividend untouched
                    resp_data <= req_op[1] ? req_a : '1;
                    resp_rd   <= req_rd;
                end else begin
                    md_mode <= req_op[2];
                    md_a    <= abs_a;
                    md_b    <= abs_b;
                end
            end

            if ((state == S_WAIT) && md_ready && !flush) begin
                resp_data <= result;
                resp_rd   <= rd_q;
            end
        end
    end

endmodule
